exc_pipe_ctrl: RTL and testbench
================================

# exc_pipe_ctrl

Pipelined exception/interrupt controller for the P7 five-stage MIPS core. It detects faults in the F, D, E and M stages and carries a 5-bit ExcCode alongside each instruction to M, where the precise commit decision is made. It arbitrates against parametrised hardware interrupts, drives the pipeline flush and handler redirect, and holds EPC, BD and EXL through an explicit NORMAL/HANDLER state machine. It is the successor of the combinational M-stage code generator, generalised over device count and address map.

## Interface
- N_HWINT, 6: number of hardware interrupt lines.
- DM_TOP, 32'h3000: first address above data memory.
- N_DEV, 2: number of memory-mapped devices.
- DEV_BASE, 32'h7f00: base of device 0.
- DEV_STRIDE, 32'h10: spacing between device windows.
- DEV_SPAN, 12: bytes decoded per device window.
- DEV_RO_OFF, 8: word offset within each window that is read-only (count register).
- PC_LO / PC_HI, 32'h3000 / 32'h6ffc: legal fetch range, inclusive.
- HANDLER_PC, 32'h4180: exception entry address.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- stall  in  1  hazard stall: F/D hold, E receives a bubble.
- f_pc  in  32  fetch PC.
- d_ri  in  1  D-stage instruction is unrecognised.
- e_ov_arith  in  1  E-stage add/addi/sub signed overflow.
- e_ov_addr  in  1  E-stage load/store address computation overflow.
- m_pc  in  32  M-stage PC.
- m_bd  in  1  M-stage instruction is in a delay slot.
- m_addr  in  32  M-stage data address.
- m_ldtype  in  3  000 none, 001 BU, 010 BS, 011 HU, 100 HS, 111 W.
- m_byteen  in  4  store byte enables (0 = no store).
- m_eret  in  1  eret in M.
- hw_int  in  N_HWINT  level-sensitive interrupt lines.
- im  in  N_HWINT  interrupt mask from SR; ie  in  1  global enable.
- exc_take  out  1  exception/interrupt taken this cycle (combinational).
- exc_code  out  5  code of the taken event (0 = interrupt).
- redirect_pc  out  32  HANDLER_PC on take, epc on eret.
- flush  out  1  = exc_take | (m_eret & state==HANDLER).
- epc  out  32; bd  out  1; exl  out  1; ip  out  N_HWINT; exc_in_handler  out  1 (sticky).

## Operation
- Stage codes: F: 4 if f_pc[1:0]!=0 or f_pc outside [PC_LO,PC_HI]. D: 10 if d_ri and the incoming code is 0. E: 12 if e_ov_arith and the incoming code is 0. e_ov_addr is carried as a flag to M. An earlier nonzero code is never overwritten.
- M checks apply only when the incoming code is 0. A load (m_ldtype!=0) or store (m_byteen!=0) faults as AdEL (4) or AdES (5) when any of the following holds:
  - the carried ov_addr flag is set;
  - the address is misaligned (W and addr[1:0]!=0; H and addr[0]);
  - the address is outside [0,DM_TOP) and outside every window [DEV_BASE+i*DEV_STRIDE, +DEV_SPAN), i<N_DEV;
  - the access is sub-word inside a device window;
  - a store targets offset DEV_RO_OFF inside a device window.
- Interrupt pending: int_req = |(ip & im) & ie & state==NORMAL. It has priority over the M code and gives exc_code 0.
- FSM NORMAL (exl=0) / HANDLER (exl=1):
  - NORMAL -> HANDLER on exc_take. EPC <= m_bd ? m_pc-4 : m_pc; bd <= m_bd.
  - HANDLER -> NORMAL on m_eret. redirect_pc = epc.
  - In HANDLER, a nonzero M code does not take. It sets exc_in_handler, which clears only on reset.
- exc_take = state==NORMAL & (int_req | m_code!=0).

## Timing
- Reset values: every stage code 0, ov flag 0, state NORMAL, epc 0, bd 0, ip 0, exc_in_handler 0. All outputs are 0 except redirect_pc=HANDLER_PC while not erting.
- ip <= hw_int registered each cycle. An interrupt asserted in cycle n can take in cycle n+1 at the earliest.
- Code pipeline: F->D->E->M, one register per stage. Latency from F detection to M decision is 3 edges without stalls.
- stall: the D code holds; E gets code 0 and ov 0; M advances normally.
- flush has priority over stall. At the next edge all D/E/M codes and flags clear to 0, and state/EPC update at the same edge.
- m_eret in NORMAL is ignored: no flush, no state change.
- An interrupt and an M fault in the same cycle: the interrupt wins (code 0), EPC=m_pc. The faulting instruction re-executes after eret.
- Reset asserted mid-handler returns the block to NORMAL at the next edge.

## Test plan
- f_pc=32'h3002, no stalls -> exc_take=1 three edges later with exc_code=4, epc=32'h3002, redirect_pc=32'h4180, exl=1 the following cycle.
- Store sw to m_addr=32'h7f08 (N_DEV=2) -> exc_code=5; sh to 32'h7f14 -> 5; lw from 32'h7f18 -> no exception; lb from 32'h2fff -> none; lw from 32'h7f0c -> 4.
- hw_int[2]=1, im[2]=1, ie=1, m_bd=1, m_pc=32'h3010 -> take with code 0, epc=32'h300c, bd=1. A later m_eret -> flush, redirect_pc=32'h300c, exl=0.
- d_ri=1 in the same instruction that had PC fault 4 -> code 4 reaches M, not 10. A stall in the D cycle -> the code holds one extra edge and E sees a bubble (code 0).
- In HANDLER, an M overflow arrives (code 12) -> exc_take=0, exc_in_handler=1, epc unchanged. An interrupt during HANDLER is not taken.
- reset=0 for one edge while in HANDLER with nonzero D/E/M codes -> all codes 0, exl=0, epc=0, exc_in_handler=0.

Source files
------------

// File: rtl/exc_pipe_ctrl_if.sv
// Bundle of pipeline-side signals for the exception controller.
// The core drives through master; the controller connects through slave.
interface exc_pipe_ctrl_if #(
  parameter int N_HWINT = 6
);
  logic                stall;
  logic [31:0]         f_pc;
  logic                d_ri;
  logic                e_ov_arith;
  logic                e_ov_addr;
  logic [31:0]         m_pc;
  logic                m_bd;
  logic [31:0]         m_addr;
  logic [2:0]          m_ldtype;
  logic [3:0]          m_byteen;
  logic                m_eret;
  logic [N_HWINT-1:0]  hw_int;
  logic [N_HWINT-1:0]  im;
  logic                ie;

  logic                exc_take;
  logic [4:0]          exc_code;
  logic [31:0]         redirect_pc;
  logic                flush;
  logic [31:0]         epc;
  logic                bd;
  logic                exl;
  logic [N_HWINT-1:0]  ip;
  logic                exc_in_handler;

  modport master (
    output stall, f_pc, d_ri, e_ov_arith, e_ov_addr, m_pc, m_bd, m_addr,
           m_ldtype, m_byteen, m_eret, hw_int, im, ie,
    input  exc_take, exc_code, redirect_pc, flush, epc, bd, exl, ip,
           exc_in_handler
  );

  modport slave (
    input  stall, f_pc, d_ri, e_ov_arith, e_ov_addr, m_pc, m_bd, m_addr,
           m_ldtype, m_byteen, m_eret, hw_int, im, ie,
    output exc_take, exc_code, redirect_pc, flush, epc, bd, exl, ip,
           exc_in_handler
  );
endinterface

// File: rtl/exc_pipe_ctrl.sv
// Precise exception/interrupt controller: carries ExcCodes F->D->E->M,
// decides at M, and holds EPC/BD/EXL through a NORMAL/HANDLER FSM.
module exc_pipe_ctrl #(
  parameter int          N_HWINT    = 6,
  parameter logic [31:0] DM_TOP     = 32'h3000,
  parameter int          N_DEV      = 2,
  parameter logic [31:0] DEV_BASE   = 32'h7f00,
  parameter logic [31:0] DEV_STRIDE = 32'h10,
  parameter logic [31:0] DEV_SPAN   = 32'd12,
  parameter logic [31:0] DEV_RO_OFF = 32'd8,
  parameter logic [31:0] PC_LO      = 32'h3000,
  parameter logic [31:0] PC_HI      = 32'h6ffc,
  parameter logic [31:0] HANDLER_PC = 32'h4180
) (
  input  logic           clk,
  input  logic           reset,
  exc_pipe_ctrl_if.slave bus
);
  typedef enum logic {S_NORMAL = 1'b0, S_HANDLER = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [4:0]         r_d_code, r_e_code, r_m_code;
  logic               r_m_ov;
  logic [31:0]        r_epc;
  logic               r_bd;
  logic [N_HWINT-1:0] r_ip;
  logic               r_exc_in_handler;

  logic [4:0]  w_f_code, w_m_code;
  logic        w_is_store, w_access, w_word, w_half, w_misalign;
  logic        w_in_dm, w_in_dev, w_ro_hit, w_mem_fault;
  logic [31:0] w_base, w_off;
  logic        w_int_req, w_take, w_eret_go, w_flush;

  assign w_f_code = ((bus.f_pc[1:0] != 2'b00) || (bus.f_pc < PC_LO) || (bus.f_pc > PC_HI))
                    ? 5'd4 : 5'd0;

  // Access size comes from the store byte-enable count or the load type.
  always_comb begin
    w_is_store = (bus.m_byteen != 4'b0000);
    w_access   = w_is_store || (bus.m_ldtype != 3'b000);
    w_word     = w_is_store ? (bus.m_byteen == 4'b1111) : (bus.m_ldtype == 3'b111);
    w_half     = w_is_store ? ($countones(bus.m_byteen) == 2)
                            : ((bus.m_ldtype == 3'b011) || (bus.m_ldtype == 3'b100));
    w_misalign = (w_word && (bus.m_addr[1:0] != 2'b00)) || (w_half && bus.m_addr[0]);
    w_in_dm    = (bus.m_addr < DM_TOP);
    w_in_dev   = 1'b0;
    w_off      = 32'd0;
    w_base     = 32'd0;
    for (int i = 0; i < N_DEV; i++) begin
      w_base = DEV_BASE + DEV_STRIDE * 32'(i);
      if ((bus.m_addr >= w_base) && (bus.m_addr < w_base + DEV_SPAN)) begin
        w_in_dev = 1'b1;
        w_off    = bus.m_addr - w_base;
      end
    end
    w_ro_hit    = w_in_dev && w_is_store && (w_off[31:2] == DEV_RO_OFF[31:2]);
    w_mem_fault = w_access && (r_m_ov || w_misalign || !(w_in_dm || w_in_dev) ||
                               (w_in_dev && !w_word) || w_ro_hit);
    if (r_m_code != 5'd0)  w_m_code = r_m_code;
    else if (w_mem_fault)  w_m_code = w_is_store ? 5'd5 : 5'd4;
    else                   w_m_code = 5'd0;
  end

  assign w_int_req = (|(r_ip & bus.im)) && bus.ie && (r_state == S_NORMAL);

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_eret_go   = 1'b0;
    case (r_state)
      S_NORMAL: begin
        if (w_int_req || (w_m_code != 5'd0)) begin
          w_take      = 1'b1;
          w_state_nxt = S_HANDLER;
        end
      end
      S_HANDLER: begin
        if (bus.m_eret) begin
          w_eret_go   = 1'b1;
          w_state_nxt = S_NORMAL;
        end
      end
      default: w_state_nxt = S_NORMAL;
    endcase
  end

  assign w_flush = w_take || w_eret_go;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= S_NORMAL;
      r_d_code         <= 5'd0;
      r_e_code         <= 5'd0;
      r_m_code         <= 5'd0;
      r_m_ov           <= 1'b0;
      r_epc            <= 32'd0;
      r_bd             <= 1'b0;
      r_ip             <= '0;
      r_exc_in_handler <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ip    <= bus.hw_int;
      if (w_take) begin
        r_epc <= bus.m_bd ? (bus.m_pc - 32'd4) : bus.m_pc;
        r_bd  <= bus.m_bd;
      end
      if ((r_state == S_HANDLER) && (w_m_code != 5'd0)) r_exc_in_handler <= 1'b1;
      // Flush beats stall: every in-flight code is discarded.
      if (w_flush) begin
        r_d_code <= 5'd0;
        r_e_code <= 5'd0;
        r_m_code <= 5'd0;
        r_m_ov   <= 1'b0;
      end else begin
        if (!bus.stall) r_d_code <= w_f_code;
        if (bus.stall)                r_e_code <= 5'd0;
        else if (r_d_code != 5'd0)    r_e_code <= r_d_code;
        else                          r_e_code <= bus.d_ri ? 5'd10 : 5'd0;
        if (r_e_code != 5'd0)         r_m_code <= r_e_code;
        else                          r_m_code <= bus.e_ov_arith ? 5'd12 : 5'd0;
        r_m_ov <= bus.e_ov_addr;
      end
    end
  end

  assign bus.exc_take       = w_take;
  assign bus.exc_code       = (w_take && !w_int_req) ? w_m_code : 5'd0;
  assign bus.redirect_pc    = w_eret_go ? r_epc : HANDLER_PC;
  assign bus.flush          = w_flush;
  assign bus.epc            = r_epc;
  assign bus.bd             = r_bd;
  assign bus.exl            = (r_state == S_HANDLER);
  assign bus.ip             = r_ip;
  assign bus.exc_in_handler = r_exc_in_handler;
endmodule

// File: tb/tb_exc_pipe_ctrl.sv
// Bench for exc_pipe_ctrl: instruction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_exc_pipe_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exc_pipe_ctrl_if #(.N_HWINT(6)) bus ();
  exc_pipe_ctrl #(.N_HWINT(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          model_ok = 0;
  bit          m_handler, m_bd_r, m_sticky, m_ov;
  logic [31:0] m_epc;
  logic [5:0]  m_ip;
  logic [4:0]  p_d, p_e, p_m;
  logic        x_take, x_flush, x_eretgo;
  logic [4:0]  x_code, x_mcode;
  logic [31:0] x_redir;

  function automatic logic [4:0] pc_exp(logic [31:0] pc);
    return ((pc % 4) != 0 || pc < 32'h3000 || pc > 32'h6ffc) ? 5'd4 : 5'd0;
  endfunction

  function automatic logic [4:0] mem_exp(logic [31:0] addr, logic [2:0] ldt,
                                         logic [3:0] be, bit ov);
    bit store, in_dm, in_dev, bad;
    int size;
    logic [31:0] base, off;
    if (ldt == 0 && be == 0) return 5'd0;
    store = (be != 0);
    if (store) size = $countones(be);
    else size = (ldt == 3'd7) ? 4 : ((ldt == 3'd3 || ldt == 3'd4) ? 2 : 1);
    in_dm = (addr < 32'h3000);
    in_dev = 0; off = 0;
    for (int i = 0; i < 2; i++) begin
      base = 32'h7f00 + i * 32'h10;
      if (addr >= base && addr < base + 12) begin in_dev = 1; off = addr - base; end
    end
    bad = ov || (size == 4 && addr % 4 != 0) || (size == 2 && addr % 2 != 0) ||
          (!in_dm && !in_dev) || (in_dev && size != 4) || (in_dev && store && off / 4 == 2);
    return bad ? (store ? 5'd5 : 5'd4) : 5'd0;
  endfunction

  task automatic model_comb();
    bit int_req;
    x_mcode  = (p_m != 0) ? p_m : mem_exp(bus.m_addr, bus.m_ldtype, bus.m_byteen, m_ov);
    int_req  = !m_handler && bus.ie && ((m_ip & bus.im) != 0);
    x_take   = !m_handler && (int_req || x_mcode != 0);
    x_code   = (x_take && !int_req) ? x_mcode : 5'd0;
    x_eretgo = m_handler && bus.m_eret;
    x_flush  = x_take || x_eretgo;
    x_redir  = x_eretgo ? m_epc : 32'h4180;
  endtask

  always @(posedge clk) begin
    logic [4:0] nd, ne, nm;
    model_comb();
    if (!reset) begin
      model_ok = 1; m_handler = 0; m_bd_r = 0; m_sticky = 0; m_ov = 0;
      m_epc = 0; m_ip = 0; p_d = 0; p_e = 0; p_m = 0;
    end else begin
      if (m_handler && x_mcode != 0) m_sticky = 1;
      if (x_take) begin
        m_handler = 1; m_epc = bus.m_bd ? bus.m_pc - 4 : bus.m_pc; m_bd_r = bus.m_bd;
      end else if (x_eretgo) m_handler = 0;
      if (x_flush) begin
        p_d = 0; p_e = 0; p_m = 0; m_ov = 0;
      end else begin
        nm = (p_e != 0) ? p_e : (bus.e_ov_arith ? 5'd12 : 5'd0);
        ne = bus.stall ? 5'd0 : ((p_d != 0) ? p_d : (bus.d_ri ? 5'd10 : 5'd0));
        nd = bus.stall ? p_d : pc_exp(bus.f_pc);
        p_d = nd; p_e = ne; p_m = nm; m_ov = bus.e_ov_addr;
      end
      m_ip = bus.hw_int;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      model_comb();
      check("cyc_take",   32'(bus.exc_take),       32'(x_take));
      check("cyc_code",   32'(bus.exc_code),       32'(x_code));
      check("cyc_redir",  bus.redirect_pc,         x_redir);
      check("cyc_flush",  32'(bus.flush),          32'(x_flush));
      check("cyc_epc",    bus.epc,                 m_epc);
      check("cyc_bd",     32'(bus.bd),             32'(m_bd_r));
      check("cyc_exl",    32'(bus.exl),            32'(m_handler));
      check("cyc_ip",     32'(bus.ip),             32'(m_ip));
      check("cyc_sticky", 32'(bus.exc_in_handler), 32'(m_sticky));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.f_pc = 32'h3000; bus.d_ri = 0; bus.e_ov_arith = 0;
    bus.e_ov_addr = 0; bus.m_pc = 32'h0; bus.m_bd = 0; bus.m_addr = 0;
    bus.m_ldtype = 0; bus.m_byteen = 0; bus.m_eret = 0; bus.hw_int = 0;
    bus.im = 0; bus.ie = 0;
  endtask

  task automatic leave_handler();
    bus.m_eret = 1; tick(); bus.m_eret = 0;
  endtask

  task automatic mem_case(string name, logic [31:0] addr, logic [2:0] ldt,
                          logic [3:0] be, logic [4:0] exp);
    bus.m_pc = 32'h3100; bus.m_addr = addr; bus.m_ldtype = ldt; bus.m_byteen = be;
    #1;
    check({name, "_code"}, 32'(bus.exc_code), 32'(exp));
    check({name, "_take"}, 32'(bus.exc_take), 32'(exp != 0));
    tick();
    bus.m_ldtype = 0; bus.m_byteen = 0; bus.m_addr = 0;
    if (exp != 0) begin
      #1 check({name, "_epc"}, bus.epc, 32'h3100);
      leave_handler();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 0; tick(); tick(); #1;
    check("rst_take",   32'(bus.exc_take), 0);
    check("rst_redir",  bus.redirect_pc, 32'h4180);
    check("rst_epc",    bus.epc, 0);
    check("rst_exl",    32'(bus.exl), 0);
    check("rst_sticky", 32'(bus.exc_in_handler), 0);
    reset = 1;

    // Misaligned fetch reaches M after three edges.
    bus.f_pc = 32'h3002; tick(); bus.f_pc = 32'h3000; tick(); tick();
    bus.m_pc = 32'h3002; #1;
    check("f4_take",  32'(bus.exc_take), 1);
    check("f4_code",  32'(bus.exc_code), 4);
    check("f4_redir", bus.redirect_pc, 32'h4180);
    check("f4_flush", 32'(bus.flush), 1);
    tick(); bus.m_pc = 0; #1;
    check("f4_exl", 32'(bus.exl), 1);
    check("f4_epc", bus.epc, 32'h3002);
    bus.m_eret = 1; #1;
    check("eret_flush", 32'(bus.flush), 1);
    check("eret_redir", bus.redirect_pc, 32'h3002);
    tick(); bus.m_eret = 0; #1;
    check("eret_exl", 32'(bus.exl), 0);

    // eret in NORMAL is ignored.
    bus.m_eret = 1; #1;
    check("eret_norm_flush", 32'(bus.flush), 0);
    check("eret_norm_redir", bus.redirect_pc, 32'h4180);
    tick(); bus.m_eret = 0; #1;
    check("eret_norm_exl", 32'(bus.exl), 0);

    // Data address checks.
    mem_case("sw_ro",    32'h7f08, 3'd0, 4'b1111, 5'd5);
    mem_case("sh_dev",   32'h7f14, 3'd0, 4'b0011, 5'd5);
    mem_case("lw_dev1",  32'h7f18, 3'd7, 4'b0000, 5'd0);
    mem_case("lb_dm",    32'h2fff, 3'd2, 4'b0000, 5'd0);
    mem_case("lw_gap",   32'h7f0c, 3'd7, 4'b0000, 5'd4);
    mem_case("lh_mis",   32'h0101, 3'd4, 4'b0000, 5'd4);
    mem_case("lw_dm",    32'h0100, 3'd7, 4'b0000, 5'd0);
    mem_case("sw_dmtop", 32'h3000, 3'd0, 4'b1111, 5'd5);
    mem_case("lw_past",  32'h7f1c, 3'd7, 4'b0000, 5'd4);

    // Carried address-overflow flag faults the load at M.
    bus.e_ov_addr = 1; tick(); bus.e_ov_addr = 0;
    mem_case("ov_addr", 32'h0100, 3'd7, 4'b0000, 5'd4);

    // Interrupt in a delay slot.
    bus.hw_int = 6'b000100; bus.im = 6'b000100; bus.ie = 1; #1;
    check("int_early", 32'(bus.exc_take), 0);
    tick(); bus.m_bd = 1; bus.m_pc = 32'h3010; #1;
    check("int_take", 32'(bus.exc_take), 1);
    check("int_code", 32'(bus.exc_code), 0);
    tick(); bus.m_bd = 0; #1;
    check("int_epc",  bus.epc, 32'h300c);
    check("int_bd",   32'(bus.bd), 1);
    check("int_hold", 32'(bus.exc_take), 0);
    tick(); bus.hw_int = 0; tick();
    bus.m_eret = 1; #1;
    check("int_eret_redir", bus.redirect_pc, 32'h300c);
    tick(); bus.m_eret = 0; #1;
    check("int_eret_exl", 32'(bus.exl), 0);

    // Interrupt and M fault together: interrupt wins.
    bus.hw_int = 6'b000100; tick();
    bus.m_pc = 32'h3020; bus.m_ldtype = 3'd7; bus.m_addr = 32'h7f0c; #1;
    check("both_code", 32'(bus.exc_code), 0);
    check("both_take", 32'(bus.exc_take), 1);
    tick(); bus.m_ldtype = 0; bus.m_addr = 0; bus.hw_int = 0; #1;
    check("both_epc", bus.epc, 32'h3020);
    tick(); leave_handler();

    // PC fault beats a later RI; a D stall adds one edge of latency.
    bus.f_pc = 32'h3001; tick();
    bus.f_pc = 32'h3000; bus.d_ri = 1; bus.stall = 1; tick();
    bus.stall = 0; tick();
    bus.d_ri = 0; #1;
    check("stall_bubble", 32'(bus.exc_take), 0);
    tick(); bus.m_pc = 32'h3004; #1;
    check("stall_take", 32'(bus.exc_take), 1);
    check("stall_code", 32'(bus.exc_code), 4);
    tick(); leave_handler();

    // Fault while in HANDLER only sets the sticky flag.
    bus.m_pc = 32'h3200; bus.m_ldtype = 3'd7; bus.m_addr = 32'h7f0c; #1;
    check("h_enter", 32'(bus.exc_take), 1);
    tick(); bus.m_ldtype = 0; bus.m_addr = 0;
    bus.e_ov_arith = 1; bus.hw_int = 6'b000100; tick();
    bus.e_ov_arith = 0; #1;
    check("h_ov_take",  32'(bus.exc_take), 0);
    check("h_ov_flush", 32'(bus.flush), 0);
    tick(); #1;
    check("h_sticky", 32'(bus.exc_in_handler), 1);
    check("h_epc",    bus.epc, 32'h3200);

    // Reset mid-handler with codes in flight.
    bus.f_pc = 32'h3001; bus.d_ri = 1; bus.e_ov_arith = 1; tick(); tick();
    reset = 0; tick(); reset = 1;
    bus.f_pc = 32'h3000; bus.d_ri = 0; bus.e_ov_arith = 0; bus.hw_int = 0; #1;
    check("rst2_exl",    32'(bus.exl), 0);
    check("rst2_epc",    bus.epc, 0);
    check("rst2_sticky", 32'(bus.exc_in_handler), 0);
    for (int i = 0; i < 3; i++) begin
      check("rst2_take", 32'(bus.exc_take), 0);
      tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
